ra_pq_array: RTL and testbench
==============================

RA_PQ_ARRAY -- requirements
Module: ra_pq_array

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries in the register array (DEPTH >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 enq  input  1  insert kvi this cycle.
REQ-005 deq  input  1  remove top item this cycle.
REQ-006 kvi  input  kv_t  key-value item to insert.
REQ-007 kvo  output  kv_t  current highest-key item (registered entry 0).
REQ-008 full  output  1  count == DEPTH.
REQ-009 empty  output  1  count == 0.
REQ-010 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-011 One clock; reset is synchronous and active-high: clk and rst as named above; polarity and synchronicity fixed.

Function
REQ-012 Entries e[0..DEPTH-1] SHALL always be sorted by key, non-increasing, e[0] highest; invalid entries hold {KEYNEGINF,VAL0}.
REQ-013 kvo SHALL equal e[0]; every effect of an operation SHALL be visible on kvo/full/empty/count exactly one cycle after the requesting edge.
REQ-014 Enq only, not full: kvi inserted below all entries with key >= kvi.key (FIFO order among equal keys); lower entries shift down by one; count +1.
REQ-015 Deq only, not empty: e[i] <= e[i+1] for all i; e[DEPTH-1] <= {KEYNEGINF,VAL0}; count -1.
REQ-016 Enq and deq in the same cycle, not empty (replace): result SHALL equal the sorted merge of e[1..DEPTH-1] and kvi, existing entries ahead of kvi on equal keys; count unchanged; permitted when full.
REQ-017 Enq and deq in the same cycle when empty: treated as enq only.
REQ-018 Enq when full without deq: ignored, array and count unchanged.
REQ-019 Deq when empty without enq: ignored, kvo remains {KEYNEGINF,VAL0}.
REQ-020 Validity SHALL be tracked by count only; an inserted item with key KEYNEGINF is a valid entry.
REQ-021 Each entry SHALL be updated in a single cycle from its own value, its neighbours and kvi; no multi-cycle state machine; sustained one op per cycle.

Reset
REQ-022 On rst, every entry SHALL load {KEYNEGINF,VAL0} and count 0, so empty=1, full=0, kvo={KEYNEGINF,VAL0} after the edge.
REQ-023 rst SHALL override enq/deq in the same cycle; a pending operation is discarded.

Configuration
REQ-024 Macro RA_PQ_ERR_EN defined: add outputs err_ovf and err_unf (1 bit each), sticky, set by REQ-018 and REQ-019 events respectively, cleared only by rst.
REQ-025 RA_PQ_ERR_EN undefined: the ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 kv_t, KEYW, VALW, KEYNEGINF and VAL0 SHALL come from pq_pkg; no new package types are required.
REQ-027 One sub-module ra_pq_cell per entry: holds one kv_t register, selects keep / take-upper / take-lower / take-kvi from compare results supplied by its neighbours.
REQ-028 Count/full/empty logic SHALL reside in ra_pq_array, not in the cells.

Verification
REQ-029 rst, then enq keys 5,9,1,7 on consecutive cycles -> kvo keys 5,9,9,9; count 4; deq x4 -> kvo 9,7,5,1 then empty=1.
REQ-030 Enq keys 4(val A),4(val B) -> deq returns A before B.
REQ-031 Fill DEPTH=8 with keys 1..8, enq key 20 -> ignored, full=1, count 8, err_ovf=1 with RA_PQ_ERR_EN.
REQ-032 Full with keys 1..8, enq+deq key 3 -> kvo 7, count 8, subsequent drain gives 7,6,5,4,3,3,2,1.
REQ-033 Empty, deq -> kvo {KEYNEGINF,VAL0}, count 0, err_unf=1 with RA_PQ_ERR_EN; empty enq+deq key 6 -> kvo 6, count 1.
REQ-034 Enq key 10 with rst high same cycle -> empty=1, count 0, kvo {KEYNEGINF,VAL0}.

Source files
------------

// File: rtl/pq_pkg.sv
`default_nettype none
// ============================================================================
//  pq_pkg : shared key/value item type and sentinel constants for pq blocks
//  Revision: 1.0
// ============================================================================
package pq_pkg;
   localparam int KEYW = 8;
   localparam int VALW = 8;

   typedef struct packed {
      logic [KEYW-1:0] key;
      logic [VALW-1:0] val;
   } kv_t;

   localparam logic [KEYW-1:0] KEYNEGINF = '0;
   localparam logic [VALW-1:0] VAL0      = '0;
   localparam kv_t             KV_EMPTY  = '{key: KEYNEGINF, val: VAL0};
endpackage
`default_nettype wire

// File: rtl/ra_pq_array_if.sv
`default_nettype none
// ============================================================================
//  ra_pq_array_if : operation/status bundle of the register-array priority queue
//  Revision: 1.0   (err_ovf/err_unf present only with RA_PQ_ERR_EN)
// ============================================================================
interface ra_pq_array_if #(
   parameter int DEPTH = 8
) ();
   import pq_pkg::*;

   logic                       enq;
   logic                       deq;
   kv_t                        kvi;
   kv_t                        kvo;
   logic                       full;
   logic                       empty;
   logic [$clog2(DEPTH+1)-1:0] count;
`ifdef RA_PQ_ERR_EN
   logic                       err_ovf;
   logic                       err_unf;
`endif

   modport master (
      output enq, deq, kvi,
      input  kvo, full, empty, count
`ifdef RA_PQ_ERR_EN
      , input err_ovf, err_unf
`endif
   );

   modport slave (
      input  enq, deq, kvi,
      output kvo, full, empty, count
`ifdef RA_PQ_ERR_EN
      , output err_ovf, err_unf
`endif
   );
endinterface
`default_nettype wire

// File: rtl/ra_pq_cell.sv
`default_nettype none
// ============================================================================
//  ra_pq_cell : one sorted-array entry; picks keep/upper/lower/kvi each cycle
//  Revision: 1.0
// ============================================================================
module ra_pq_cell
   import pq_pkg::*;
#(
   parameter bit FIRST = 1'b0
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic ins_i,
   input  wire logic del_i,
   input  wire logic valid_i,
   input  wire kv_t  kvi_i,
   input  wire kv_t  upper_kv_i,
   input  wire kv_t  lower_kv_i,
   input  wire logic upper_ge_i,
   input  wire logic lower_ge_i,
   output logic      ge_o,
   output kv_t       kv_o
);
   typedef enum logic [1:0] {
      SEL_KEEP  = 2'd0,
      SEL_UPPER = 2'd1,
      SEL_LOWER = 2'd2,
      SEL_KVI   = 2'd3
   } sel_e;

   kv_t  kv_q, kv_d;
   sel_e sel_d;

   assign ge_o = valid_i && (kv_q.key >= kvi_i.key);
   assign kv_o = kv_q;

   always_comb begin
      sel_d = SEL_KEEP;
      if (ins_i && del_i) begin
         // Replace: merge of the entries below the head with kvi, kvi after equals
         if (lower_ge_i)            sel_d = SEL_LOWER;
         else if (FIRST || ge_o)    sel_d = SEL_KVI;
      end else if (ins_i) begin
         if (ge_o)                    sel_d = SEL_KEEP;
         else if (FIRST || upper_ge_i) sel_d = SEL_KVI;
         else                         sel_d = SEL_UPPER;
      end else if (del_i) begin
         sel_d = SEL_LOWER;
      end

      kv_d = kv_q;
      case (sel_d)
         SEL_UPPER: kv_d = upper_kv_i;
         SEL_LOWER: kv_d = lower_kv_i;
         SEL_KVI:   kv_d = kvi_i;
         default:   kv_d = kv_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) kv_q <= KV_EMPTY;
      else     kv_q <= kv_d;
   end
endmodule
`default_nettype wire

// File: rtl/ra_pq_array.sv
`default_nettype none
// ============================================================================
//  ra_pq_array : register-array priority queue, highest key at entry 0
//  Revision: 1.0   (define RA_PQ_ERR_EN for sticky err_ovf/err_unf flags)
// ============================================================================
module ra_pq_array
   import pq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input wire logic    clk,
   input wire logic    rst,
   ra_pq_array_if.slave bus
);
   localparam int CW = $clog2(DEPTH+1);

   logic [CW-1:0]    count_q, count_d;
   logic             w_full, w_empty, w_ins, w_del, w_rep;
   logic [DEPTH:0]   w_ge;
   kv_t              w_e [DEPTH];

   assign w_full  = (count_q == CW'(DEPTH));
   assign w_empty = (count_q == '0);

   // Replace only needs a head to drop; on an empty array enq+deq is a plain insert
   assign w_rep = bus.enq && bus.deq && !w_empty;
   assign w_ins = bus.enq && !w_rep && !w_full;
   assign w_del = bus.deq && !bus.enq && !w_empty;

   assign w_ge[DEPTH] = 1'b0;

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      kv_t  w_upper_kv, w_lower_kv;
      logic w_upper_ge;

      if (i == 0) begin : g_top
         assign w_upper_kv = KV_EMPTY;
         assign w_upper_ge = 1'b0;
      end else begin : g_mid_up
         assign w_upper_kv = w_e[i-1];
         assign w_upper_ge = w_ge[i-1];
      end

      if (i == DEPTH-1) begin : g_bot
         assign w_lower_kv = KV_EMPTY;
      end else begin : g_mid_dn
         assign w_lower_kv = w_e[i+1];
      end

      ra_pq_cell #(.FIRST(i == 0)) u_cell (
         .clk        (clk),
         .rst        (rst),
         .ins_i      (w_ins || w_rep),
         .del_i      (w_del || w_rep),
         .valid_i    (count_q > CW'(i)),
         .kvi_i      (bus.kvi),
         .upper_kv_i (w_upper_kv),
         .lower_kv_i (w_lower_kv),
         .upper_ge_i (w_upper_ge),
         .lower_ge_i (w_ge[i+1]),
         .ge_o       (w_ge[i]),
         .kv_o       (w_e[i])
      );
   end

   always_comb begin
      count_d = count_q;
      if (w_ins)      count_d = count_q + CW'(1);
      else if (w_del) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign bus.kvo   = w_e[0];
   assign bus.count = count_q;
   assign bus.full  = w_full;
   assign bus.empty = w_empty;

`ifdef RA_PQ_ERR_EN
   logic err_ovf_q, err_unf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         if (bus.enq && !bus.deq && w_full)  err_ovf_q <= 1'b1;
         if (bus.deq && !bus.enq && w_empty) err_unf_q <= 1'b1;
      end
   end

   assign bus.err_ovf = err_ovf_q;
   assign bus.err_unf = err_unf_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ra_pq_array.sv
`default_nettype none
// ============================================================================
//  tb_ra_pq_array : directed self-checking bench for ra_pq_array (DEPTH=8)
//  Revision: 1.0
// ============================================================================
module tb_ra_pq_array;
   import pq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   ra_pq_array_if #(.DEPTH(8)) bus ();

   ra_pq_array #(.DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic op(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v);
      bus.enq = e;
      bus.deq = d;
      bus.kvi = '{key: k, val: v};
      @(posedge clk);
      #1;
      bus.enq = 1'b0;
      bus.deq = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      total++; if (bus.kvo !== KV_EMPTY) begin bad++; $display("FAIL reset_kvo got=%h exp=%h", bus.kvo, KV_EMPTY); end
   endtask

   task automatic test_sort();
      logic [7:0] ins [4] = '{8'd5, 8'd9, 8'd1, 8'd7};
      logic [7:0] top [4] = '{8'd5, 8'd9, 8'd9, 8'd9};
      logic [7:0] drn [4] = '{8'd9, 8'd7, 8'd5, 8'd1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         op(1'b1, 1'b0, ins[i], 8'h10 + 8'(i));
         total++; if (bus.kvo.key !== top[i]) begin bad++; $display("FAIL sort_top[%0d] got=%0d exp=%0d", i, bus.kvo.key, top[i]); end
      end
      total++; if (bus.count !== 4'd4) begin bad++; $display("FAIL sort_count got=%0d exp=4", bus.count); end
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.kvo.key !== drn[i]) begin bad++; $display("FAIL sort_drain[%0d] got=%0d exp=%0d", i, bus.kvo.key, drn[i]); end
         op(1'b0, 1'b1, 8'd0, 8'd0);
      end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL sort_empty got=%b exp=1", bus.empty); end
   endtask

   task automatic test_fifo_ties();
      do_reset();
      op(1'b1, 1'b0, 8'd4, 8'hAA);
      op(1'b1, 1'b0, 8'd4, 8'hBB);
      total++; if (bus.kvo.val !== 8'hAA) begin bad++; $display("FAIL tie_first got=%h exp=aa", bus.kvo.val); end
      op(1'b0, 1'b1, 8'd0, 8'd0);
      total++; if (bus.kvo.val !== 8'hBB) begin bad++; $display("FAIL tie_second got=%h exp=bb", bus.kvo.val); end
      op(1'b0, 1'b1, 8'd0, 8'd0);
   endtask

   task automatic test_full_replace();
      logic [7:0] ek [8] = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd3, 8'd2, 8'd1};
      logic [7:0] ev [8] = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'h33, 8'd2, 8'd1};
      do_reset();
      for (int k = 1; k <= 8; k++) op(1'b1, 1'b0, 8'(k), 8'(k));
      total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bus.full); end
      op(1'b1, 1'b0, 8'd20, 8'd20);
      total++; if (bus.kvo.key !== 8'd8) begin bad++; $display("FAIL ovf_kvo got=%0d exp=8", bus.kvo.key); end
      total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", bus.count); end
      total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", bus.full); end
`ifdef RA_PQ_ERR_EN
      total++; if (bus.err_ovf !== 1'b1) begin bad++; $display("FAIL err_ovf got=%b exp=1", bus.err_ovf); end
      total++; if (bus.err_unf !== 1'b0) begin bad++; $display("FAIL err_unf_clear got=%b exp=0", bus.err_unf); end
`endif
      op(1'b1, 1'b1, 8'd3, 8'h33);
      total++; if (bus.kvo.key !== 8'd7) begin bad++; $display("FAIL rep_kvo got=%0d exp=7", bus.kvo.key); end
      total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL rep_count got=%0d exp=8", bus.count); end
      for (int i = 0; i < 8; i++) begin
         total++; if (bus.kvo !== kv_t'{key: ek[i], val: ev[i]}) begin bad++; $display("FAIL rep_drain[%0d] got=%h exp=%h%h", i, bus.kvo, ek[i], ev[i]); end
         op(1'b0, 1'b1, 8'd0, 8'd0);
      end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rep_empty got=%b exp=1", bus.empty); end
   endtask

   task automatic test_underflow();
      do_reset();
      op(1'b0, 1'b1, 8'd0, 8'd0);
      total++; if (bus.kvo !== KV_EMPTY) begin bad++; $display("FAIL unf_kvo got=%h exp=%h", bus.kvo, KV_EMPTY); end
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL unf_count got=%0d exp=0", bus.count); end
`ifdef RA_PQ_ERR_EN
      total++; if (bus.err_unf !== 1'b1) begin bad++; $display("FAIL err_unf got=%b exp=1", bus.err_unf); end
`endif
      op(1'b1, 1'b1, 8'd6, 8'h66);
      total++; if (bus.kvo !== kv_t'{key: 8'd6, val: 8'h66}) begin bad++; $display("FAIL emp_rep_kvo got=%h exp=0666", bus.kvo); end
      total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL emp_rep_count got=%0d exp=1", bus.count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      op(1'b1, 1'b0, 8'd3, 8'h03);
      op(1'b1, 1'b0, 8'd0, 8'h00);
      total++; if (bus.count !== 4'd2) begin bad++; $display("FAIL b2b_negkey_count got=%0d exp=2", bus.count); end
      op(1'b1, 1'b1, 8'd8, 8'h08);
      total++; if (bus.kvo.key !== 8'd8) begin bad++; $display("FAIL b2b_rep1 got=%0d exp=8", bus.kvo.key); end
      op(1'b1, 1'b1, 8'd2, 8'h02);
      total++; if (bus.kvo.key !== 8'd2) begin bad++; $display("FAIL b2b_rep2 got=%0d exp=2", bus.kvo.key); end
      op(1'b0, 1'b1, 8'd0, 8'd0);
      total++; if (bus.kvo !== kv_t'{key: 8'd0, val: 8'h00}) begin bad++; $display("FAIL b2b_tail got=%h exp=0000", bus.kvo); end
      total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", bus.count); end
   endtask

   task automatic test_reset_override();
      op(1'b1, 1'b0, 8'd9, 8'h09);
      rst     = 1'b1;
      bus.enq = 1'b1;
      bus.kvi = '{key: 8'd10, val: 8'h0A};
      @(posedge clk);
      #1;
      rst     = 1'b0;
      bus.enq = 1'b0;
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rstovr_empty got=%b exp=1", bus.empty); end
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL rstovr_count got=%0d exp=0", bus.count); end
      total++; if (bus.kvo !== KV_EMPTY) begin bad++; $display("FAIL rstovr_kvo got=%h exp=%h", bus.kvo, KV_EMPTY); end
`ifdef RA_PQ_ERR_EN
      total++; if (bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin bad++; $display("FAIL rstovr_err got=%b%b exp=00", bus.err_ovf, bus.err_unf); end
`endif
   endtask

   initial begin
      bus.enq = 1'b0;
      bus.deq = 1'b0;
      bus.kvi = KV_EMPTY;
      test_reset();
      test_sort();
      test_fifo_ties();
      test_full_replace();
      test_underflow();
      test_back_to_back();
      test_reset_override();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
